c432_stim_checker: RTL and testbench

Stimulus generator and response checker that drives the registered c432 fault-injection wrapper from its input side and consumes its registered outputs. It issues a programmable number of pseudo-random 36-bit vectors into the wrapper's `in` bus, one per clock. It compares the wrapper's 7-bit `out` against a fault-free golden copy's output after the wrapper's fixed pipeline latency, and reports the mismatch count, the first failing vector index and the accumulated failing bits. It sits between the host control registers and the pair of DUT wrappers (faulty and golden).

---
 rtl/c432_stim_checker.sv | 132 +++++++++++++
 tb/tb_c432_stim_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/c432_stim_checker.sv
// c432_stim_checker: drives pseudo-random 36-bit vectors into the faulty and
// golden c432 wrappers. After the fixed pipeline latency it compares their
// 7-bit responses and records the mismatch count, the failing bits and the
// index of the first failing vector.
//
// Handshake: a one-cycle `start` is accepted only in IDLE or DONE. `busy` is
// high while vectors are issued or in flight. `done` holds the final results
// until the next accepted `start`.
module c432_stim_checker #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [35:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [35:0]      dut_in,
    input  logic [6:0]       dut_out,
    input  logic [6:0]       ref_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [6:0]       err_bits,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [35:0]        lfsr;
    logic [CNT_W-1:0]   vec_total;
    logic [CNT_W-1:0]   issue_idx;
    logic [LATENCY:0]   pipe_vld;
    logic [CNT_W-1:0]   pipe_tag [LATENCY+1];
    logic               zero_hold;

    logic               accept;
    logic               cmp_vld;
    logic [CNT_W-1:0]   cmp_tag;
    logic [6:0]         diff;
    logic               mismatch;
    logic               last_issue;
    logic               last_cmp;

    assign accept     = start && (state == S_IDLE || state == S_DONE);
    assign cmp_vld    = pipe_vld[LATENCY];
    assign cmp_tag    = pipe_tag[LATENCY];
    assign diff       = dut_out ^ ref_out;
    assign mismatch   = cmp_vld && (diff != 7'd0);
    assign last_issue = (issue_idx == vec_total - CNT_W'(1));
    assign last_cmp   = cmp_vld && (cmp_tag == vec_total - CNT_W'(1));

    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    // An empty run enters DONE immediately, but `done` is held back one cycle
    // so that it appears after edge 1, as it would after a one-cycle pass.
    assign done      = (state == S_DONE) && !zero_hold;
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: issue until the last index, then drain until the last compare.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (num_vec == '0) ? S_DONE : S_RUN;
            S_RUN:          if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN:        if (last_cmp) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Tag pipe: one slot per cycle of latency plus the compare slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i <= LATENCY; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld    <= {pipe_vld[LATENCY-1:0], (state == S_RUN)};
            pipe_tag[0] <= issue_idx;
            for (int i = 1; i <= LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    // Vector generation, run setup and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr            <= 36'h1;
            vec_total       <= '0;
            issue_idx       <= '0;
            dut_in          <= '0;
            err_cnt         <= '0;
            err_bits        <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            zero_hold       <= 1'b0;
        end else begin
            zero_hold <= accept && (num_vec == '0);
            dut_in    <= (state == S_RUN) ? lfsr : 36'd0;
            if (accept) begin
                // An all-zero LFSR would lock up, so a zero seed becomes 1.
                lfsr            <= (seed == 36'd0) ? 36'h1 : seed;
                vec_total       <= num_vec;
                issue_idx       <= '0;
                err_cnt         <= '0;
                err_bits        <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
            end else begin
                if (state == S_RUN) begin
                    lfsr      <= {lfsr[34:0], lfsr[35] ^ lfsr[24]};
                    issue_idx <= issue_idx + CNT_W'(1);
                end
                if (mismatch) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                    err_bits <= err_bits | diff;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= cmp_tag;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_c432_stim_checker.sv
// Directed bench for c432_stim_checker. It uses behavioural two-stage
// models of the faulty and golden wrappers with per-vector bit-flip injection.
module tb_c432_stim_checker;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [35:0]      seed = '0;
    logic [CNT_W-1:0] num_vec = '0;
    logic [35:0]      dut_in;
    logic [6:0]       dut_out;
    logic [6:0]       ref_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [6:0]       err_bits;
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_idx;
    logic [1:0]       fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] exp_q[$];

    // Fault injection: when the vector value matches, flip the given mask.
    logic [35:0] fault_val_a = '0, fault_val_b = '0;
    logic [6:0]  fault_msk_a = '0, fault_msk_b = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- wrapper models ----------------
    logic [35:0] stage_in = '0;
    logic [6:0]  dut_q = '0, ref_q = '0;

    function automatic logic [6:0] fold(input logic [35:0] v);
        return v[6:0] ^ v[35:29] ^ v[20:14];
    endfunction

    always @(posedge clk) begin
        stage_in <= dut_in;
        ref_q    <= fold(stage_in);
        dut_q    <= fold(stage_in)
                  ^ ((stage_in == fault_val_a) ? fault_msk_a : 7'd0)
                  ^ ((stage_in == fault_val_b) ? fault_msk_b : 7'd0);
    end
    assign dut_out = dut_q;
    assign ref_out = ref_q;

    c432_stim_checker #(.LATENCY(2), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_vec(num_vec),
        .dut_in(dut_in), .dut_out(dut_out), .ref_out(ref_out),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_bits(err_bits),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
        .fsm_state(fsm_state)
    );

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_faults(input logic [35:0] va, input logic [6:0] ma,
                              input logic [35:0] vb, input logic [6:0] mb);
        fault_val_a = va; fault_msk_a = ma;
        fault_val_b = vb; fault_msk_b = mb;
    endtask

    // Drive start so that the next rising edge is edge 0.
    task automatic do_start(input logic [35:0] s, input logic [CNT_W-1:0] n);
        @(negedge clk);
        seed = s; num_vec = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walk negedges after edge 0, 1, ... until done. Expected dut_in values
    // are popped from exp_q from edge 1 onwards. Optionally pulse a junk
    // start while the run is busy.
    task automatic wait_done(input int pulse_at, output int done_edge, output bit busy_seen);
        logic [35:0] exp_v;
        done_edge = -1;
        busy_seen = 1'b0;
        for (int e = 0; e < 200; e++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            busy_seen |= busy;
            if (e >= 1 && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check_val("dut_in_seq", {28'd0, dut_in}, {28'd0, exp_v});
            end
            if (done) begin
                done_edge = e;
                break;
            end
            if (e == pulse_at) begin
                seed = 36'hABCDE; num_vec = 99; start = 1'b1;
            end
        end
        if (done_edge < 0) check_val("done_timeout", 64'd0, 64'd1);
        exp_q.delete();
    endtask

    task automatic check_results(input string tag, input int cnt, input logic [6:0] bits,
                                 input bit fev, input int fidx);
        check_val({tag, "_err_cnt"},  err_cnt, cnt);
        check_val({tag, "_err_bits"}, err_bits, bits);
        check_val({tag, "_fev"},      first_err_valid, fev);
        check_val({tag, "_fidx"},     first_err_idx, fidx);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_outs"},
                  {dut_in, busy, done, err_cnt != 0, err_bits, first_err_valid, first_err_idx != 0},
                  64'd0);
        check_val({tag, "_state"}, fsm_state, 2'd0);
    endtask

    // ---------------- main sequence ----------------
    int  de;
    bit  bs;

    initial begin
        // Reset, then stay idle for 10 cycles.
        #2;
        check_all_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("idle_quiet", {dut_in, busy, done}, 64'd0);
        end

        // Clean run: seed 0 becomes 1, so the vectors are 1, 2, 4, 8.
        set_faults('0, '0, '0, '0);
        exp_q.push_back(36'h1); exp_q.push_back(36'h2);
        exp_q.push_back(36'h4); exp_q.push_back(36'h8);
        do_start(36'd0, 4);
        wait_done(-1, de, bs);
        check_val("clean_done_edge", de, 7);
        check_val("clean_busy_seen", bs, 1);
        check_results("clean", 0, 7'h00, 0, 0);
        @(negedge clk);
        check_val("clean_dut_in_idle", {28'd0, dut_in}, 64'd0);

        // Single fault: vector 2 (value 36'h4), bit 3.
        set_faults(36'h4, 7'h08, '0, '0);
        do_start(36'h1, 8);
        wait_done(-1, de, bs);
        check_val("single_done_edge", de, 11);
        check_results("single", 1, 7'h08, 1, 2);

        // Multiple faults: vector 1 bit 0, vector 5 bit 6.
        set_faults(36'h2, 7'h01, 36'h20, 7'h40);
        do_start(36'h1, 8);
        wait_done(-1, de, bs);
        check_val("multi_done_edge", de, 11);
        check_results("multi", 2, 7'h41, 1, 1);

        // Same run with a junk start pulsed mid-run: the result must not change.
        do_start(36'h1, 8);
        wait_done(3, de, bs);
        check_val("pulse_done_edge", de, 11);
        check_results("pulse", 2, 7'h41, 1, 1);

        // Back-to-back start from DONE: clean run, counters cleared. A seed
        // with only bit 35 set exercises the feedback tap.
        set_faults('0, '0, '0, '0);
        exp_q.push_back(36'h8_0000_0000); exp_q.push_back(36'h1); exp_q.push_back(36'h2);
        do_start(36'h8_0000_0000, 3);
        wait_done(-1, de, bs);
        check_val("b2b_done_edge", de, 6);
        check_results("b2b", 0, 7'h00, 0, 0);

        // Zero-length run, started after an erroring run.
        set_faults(36'h2, 7'h01, '0, '0);
        do_start(36'h1, 4);
        wait_done(-1, de, bs);
        check_results("pre_zero", 1, 7'h01, 1, 1);
        do_start(36'h1, 0);
        wait_done(-1, de, bs);
        check_val("zero_done_edge", de, 1);
        check_val("zero_busy_seen", bs, 0);
        check_results("zero", 0, 7'h00, 0, 0);

        // Reset mid-run during cycle 3 of an 8-vector run with faults.
        set_faults(36'h1, 7'h7F, 36'h4, 7'h10);
        do_start(36'h1, 8);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_faults('0, '0, '0, '0);
        do_start(36'd0, 4);
        wait_done(-1, de, bs);
        check_val("post_reset_done_edge", de, 7);
        check_results("post_reset", 0, 7'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
